life_sequencer: RTL

Top-level scheduler for the Game of Life board. It sequences the next-generation compute engine and the screen draw engine (cell grid plus cursor ring), and decides when each runs. It serialises user edits (clear, toggle cell), single steps and free-run generation ticks. Only one engine is ever active, so the 1200-bit board state is never read by the draw engine while it is being rewritten.

---
 rtl/life_pkg.sv | 20 ++
 rtl/life_sequencer_if.sv | 39 +++
 rtl/gen_tick_divider.sv | 27 ++
 rtl/life_sequencer.sv | 120 ++++++++++++
 4 files changed

// File: rtl/life_pkg.sv
// life_pkg: shared scheduler states, board geometry and default timing for the life sequencer
//   S_INIT..S_WAIT_DRAW : 3-bit FSM encodings 0..7
//   GRID_W/GRID_H/CELLS : board geometry (40 x 30 = 1200 cells)
//   TICK_DIV_DEFAULT    : clocks per free-run generation (20 Hz at 50 MHz)
package life_pkg;
    localparam int GRID_W = 40;
    localparam int GRID_H = 30;
    localparam int CELLS = GRID_W * GRID_H;
    localparam int TICK_DIV_DEFAULT = 2500000;
    typedef enum logic [2:0] {
        S_INIT      = 3'd0,
        S_IDLE      = 3'd1,
        S_CLEAR     = 3'd2,
        S_TOGGLE    = 3'd3,
        S_COMPUTE   = 3'd4,
        S_WAIT_COMP = 3'd5,
        S_DRAW      = 3'd6,
        S_WAIT_DRAW = 3'd7
    } state_e;
endpackage

// File: rtl/life_sequencer_if.sv
// life_sequencer_if: user requests, engine handshakes and status of the life sequencer
//   master : sequencer side (drives engine starts, board edits, status)
//   slave  : environment side (user requests, engine done pulses)
//   wd_err exists only when DRAW_WATCHDOG_EN is defined
interface life_sequencer_if #(parameter int GEN_W = 16);
    logic             run;
    logic             step_req;
    logic             clear_req;
    logic             toggle_req;
    logic             compute_start;
    logic             compute_done;
    logic             clear_state;
    logic             toggle_cell;
    logic             draw_start;
    logic             draw_done;
    logic             cursor_enable;
    logic             busy;
    logic [GEN_W-1:0] generation;
`ifdef DRAW_WATCHDOG_EN
    logic             wd_err;
    modport master (
        input  run, step_req, clear_req, toggle_req, compute_done, draw_done,
        output compute_start, clear_state, toggle_cell, draw_start, cursor_enable, busy, generation, wd_err
    );
    modport slave (
        output run, step_req, clear_req, toggle_req, compute_done, draw_done,
        input  compute_start, clear_state, toggle_cell, draw_start, cursor_enable, busy, generation, wd_err
    );
`else
    modport master (
        input  run, step_req, clear_req, toggle_req, compute_done, draw_done,
        output compute_start, clear_state, toggle_cell, draw_start, cursor_enable, busy, generation
    );
    modport slave (
        output run, step_req, clear_req, toggle_req, compute_done, draw_done,
        input  compute_start, clear_state, toggle_cell, draw_start, cursor_enable, busy, generation
    );
`endif
endinterface

// File: rtl/gen_tick_divider.sv
// gen_tick_divider: run-gated saturating free-run generation tick
//   clock, reset : system clock, synchronous active-high reset
//   run          : counts only while high; low clears counter and tick
//   consume      : restarts the count (a generation compute is being entered)
//   tick         : pending free-run generation (counter parked at TICK_DIV-1)
module gen_tick_divider
    import life_pkg::*;
#(
    parameter int TICK_DIV = TICK_DIV_DEFAULT,
    parameter int CW = 22
) (
    input  logic clock,
    input  logic reset,
    input  logic run,
    input  logic consume,
    output logic tick
);
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);
    logic [CW-1:0] cnt_q, cnt_d;
    always_comb cnt_d = (!run || consume) ? '0 : (cnt_q == LAST) ? cnt_q : cnt_q + 1'b1;
    always_ff @(posedge clock) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end
    // the parked counter is the pending-tick flag; it is cleared with the count
    assign tick = cnt_q == LAST;
endmodule

// File: rtl/life_sequencer.sv
// life_sequencer: schedules the life compute and draw engines, serialising edits, steps and free-run ticks
//   clock, reset : system clock, synchronous active-high reset
//   bus (master) : run/step/clear/toggle requests, compute and draw handshakes,
//                  clear_state/toggle_cell board edits, cursor_enable, busy, generation
//   DRAW_WATCHDOG_EN : adds WD_CYCLES and sticky bus.wd_err; stuck wait states fall back to idle
module life_sequencer
    import life_pkg::*;
#(
    parameter int TICK_DIV = TICK_DIV_DEFAULT,
    parameter int CW = 22,
    parameter int GEN_W = 16
`ifdef DRAW_WATCHDOG_EN
    , parameter int WD_CYCLES = 65535
`endif
) (
    input logic              clock,
    input logic              reset,
    life_sequencer_if.master bus
);
    state_e           state_q, state_d;
    logic [GEN_W-1:0] gen_q, gen_d;
    logic             clear_p_q, toggle_p_q, step_p_q;
    logic             compute_start_q, clear_state_q, toggle_cell_q, draw_start_q, cursor_enable_q, busy_q;
    logic             tick, timeout, draw_now;

    gen_tick_divider #(.TICK_DIV(TICK_DIV), .CW(CW)) u_tick (
        .clock   (clock),
        .reset   (reset),
        .run     (bus.run),
        .consume (state_d == S_COMPUTE),
        .tick    (tick)
    );

`ifdef DRAW_WATCHDOG_EN
    logic [31:0] wd_q;
    logic        wd_err_q;
    // wd_q is the number of cycles already spent in the current state
    assign timeout = (state_q == S_WAIT_COMP || state_q == S_WAIT_DRAW) && wd_q == 32'(WD_CYCLES - 1);
    always_ff @(posedge clock) begin
        if (reset) begin
            wd_q     <= '0;
            wd_err_q <= 1'b0;
        end else begin
            wd_q     <= (state_d != state_q) ? '0 : wd_q + 32'd1;
            wd_err_q <= wd_err_q | (timeout && state_d == S_IDLE && !bus.draw_done);
        end
    end
    assign bus.wd_err = wd_err_q;
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        gen_d   = gen_q;
        case (state_q)
            S_INIT:      state_d = S_WAIT_DRAW;
            S_IDLE:      state_d = clear_p_q ? S_CLEAR : toggle_p_q ? S_TOGGLE :
                                   (step_p_q || tick) ? S_COMPUTE : S_IDLE;
            S_CLEAR: begin
                state_d = S_DRAW;
                gen_d   = '0;
            end
            S_TOGGLE:    state_d = S_DRAW;
            S_COMPUTE:   state_d = S_WAIT_COMP;
            S_WAIT_COMP: begin
                if (bus.compute_done) begin
                    state_d = S_DRAW;
                    gen_d   = gen_q + 1'b1;
                end else if (timeout) begin
                    state_d = S_IDLE;
                end
            end
            S_DRAW:      state_d = S_WAIT_DRAW;
            S_WAIT_DRAW: state_d = (bus.draw_done || timeout) ? S_IDLE : S_WAIT_DRAW;
            default:     state_d = S_INIT;
        endcase
    end

    // action pulses are registered from the state being entered so they line up
    // with that state and read 0 throughout reset; the power-up paint leaves S_INIT
    assign draw_now = state_d == S_DRAW || state_q == S_INIT;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q         <= S_INIT;
            gen_q           <= '0;
            clear_p_q       <= 1'b0;
            toggle_p_q      <= 1'b0;
            step_p_q        <= 1'b0;
            compute_start_q <= 1'b0;
            clear_state_q   <= 1'b0;
            toggle_cell_q   <= 1'b0;
            draw_start_q    <= 1'b0;
            cursor_enable_q <= 1'b0;
            busy_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            gen_q           <= gen_d;
            // a request arriving on its own dispatch edge is consumed, not kept
            clear_p_q       <= (clear_p_q | bus.clear_req) & (state_d != S_CLEAR);
            toggle_p_q      <= (toggle_p_q | bus.toggle_req) & (state_d != S_TOGGLE);
            step_p_q        <= (step_p_q | (bus.step_req & ~bus.run)) & (state_d != S_COMPUTE);
            compute_start_q <= state_d == S_COMPUTE;
            clear_state_q   <= state_d == S_CLEAR;
            toggle_cell_q   <= state_d == S_TOGGLE;
            draw_start_q    <= draw_now;
            busy_q          <= state_d != S_IDLE;
            if (draw_now) cursor_enable_q <= ~bus.run;
        end
    end

    assign bus.compute_start = compute_start_q;
    assign bus.clear_state   = clear_state_q;
    assign bus.toggle_cell   = toggle_cell_q;
    assign bus.draw_start    = draw_start_q;
    assign bus.cursor_enable = cursor_enable_q;
    assign bus.busy          = busy_q;
    assign bus.generation    = gen_q;
endmodule
